// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one RAM port between CPU and DMA
module mem_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [1:0]    cpu_cmd_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_ack_o,
  output logic [DW-1:0] cpu_rdata_o,
  input  logic [1:0]    dma_cmd_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic          dma_ack_o,
  output logic [DW-1:0] dma_rdata_o,
  output logic [1:0]    mem_cmd_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          owner_o,
  output logic          busy_o
);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, ACK} state_t;

  state_t        state_q, state_d;
  logic [1:0]    mem_cmd_q, mem_cmd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;

  logic cpu_req, dma_req, grant_dma;

  // cmd 11 is not a request and can never win
  assign cpu_req   = (cpu_cmd_i == MREAD) || (cpu_cmd_i == MWRITE);
  assign dma_req   = (dma_cmd_i == MREAD) || (dma_cmd_i == MWRITE);
  assign grant_dma = dma_req && (!cpu_req || !last_q);

  always_comb begin
    state_d     = state_q;
    mem_cmd_d   = mem_cmd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    owner_d     = owner_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          owner_d     = grant_dma;
          last_d      = grant_dma;
          mem_cmd_d   = grant_dma ? dma_cmd_i   : cpu_cmd_i;
          mem_addr_d  = grant_dma ? dma_addr_i  : cpu_addr_i;
          mem_wdata_d = grant_dma ? dma_wdata_i : cpu_wdata_i;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_cmd_q == MREAD) begin
          state_d = RWAIT;
        end else begin
          mem_cmd_d = MNONE;
          state_d   = ACK;
        end
      end
      RWAIT: begin
        if (owner_q) dma_rdata_d = mem_rdata_i;
        else         cpu_rdata_d = mem_rdata_i;
        mem_cmd_d = MNONE;
        state_d   = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      mem_cmd_q   <= MNONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      mem_cmd_q   <= mem_cmd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
    end
  end

  assign cpu_ack_o   = (state_q == ACK) && !owner_q;
  assign dma_ack_o   = (state_q == ACK) && owner_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;
  assign mem_cmd_o   = mem_cmd_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign owner_o     = owner_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single RAM port between the CPU (instruction fetch and LDR/STR traffic) and a DMA/loader requester. It sits between both requesters and the memory. It serialises their accesses with a round-robin FSM, registers the memory-side command, address and write data, and returns a one-cycle acknowledge plus captured read data to the winning requester.

## Interface
- AW, 9: address width (matches mem_addr).
- DW, 16: data width.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- cpu_cmd  in  2  CPU command: 00 MNONE, 01 MREAD, 10 MWRITE, 11 illegal.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle pulse when the CPU access completes.
- cpu_rdata  out  DW  last CPU read result, held until the next CPU read completes.
- dma_cmd  in  2  DMA command, same encoding as cpu_cmd.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_ack  out  1  one-cycle completion pulse for DMA.
- dma_rdata  out  DW  last DMA read result, held.
- mem_cmd  out  2  registered command to memory.
- mem_addr  out  AW  registered address to memory.
- mem_wdata  out  DW  registered write data to memory.
- mem_rdata  in  DW  memory read data, valid the cycle after MREAD is presented.
- owner  out  1  0 = CPU, 1 = DMA; the current or most recent grantee.
- busy  out  1  high in every state except IDLE.

## Operation
- A request means cmd is 01 or 10. cmd 11 is ignored, treated as MNONE, and never granted.
- A requester holds cmd, addr and wdata stable from assertion until the cycle its ack is high. It changes or drops the request at the edge that ends the ack cycle.
- FSM states: IDLE, ISSUE, RWAIT, ACK.
- IDLE, no request: stay in IDLE. mem_cmd = MNONE.
- IDLE, request present: pick the winner, then at the edge:
  - latch the winner's cmd/addr/wdata into the mem_* registers;
  - set owner and the `last` register to the winner;
  - go to ISSUE.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both requesting: the port that is not `last` wins (round-robin).
  - `last` resets to DMA, so the CPU wins the first tie.
- ISSUE:
  - mem_* outputs are driven.
  - MWRITE: memory commits at the edge ending ISSUE; next state is ACK.
  - MREAD: next state is RWAIT.
- RWAIT:
  - mem_cmd and mem_addr stay held.
  - mem_rdata is captured into the owner's rdata register at the edge ending RWAIT; the other port's rdata is unchanged.
  - Next state is ACK.
- ACK:
  - mem_cmd = MNONE; mem_addr and mem_wdata hold their values.
  - The owner's ack = 1 and the other port's ack = 0.
  - Next state is IDLE, unconditionally; there is no back-to-back grant from ACK.
- No starvation: while both ports keep requesting, grants alternate.
- A write never modifies either rdata register.

## Timing
- Reset values (asserted asynchronously, independent of clk):
  - state = IDLE, `last` = DMA;
  - mem_cmd = 00, mem_addr = 0, mem_wdata = 0;
  - cpu_ack = dma_ack = 0, cpu_rdata = dma_rdata = 0;
  - owner = 0, busy = 0.
- Latency, counting the first cycle the request is seen in IDLE as cycle 0:
  - write: mem_cmd = MWRITE in cycle 1, ack in cycle 2;
  - read: mem_cmd = MREAD in cycles 1–2, rdata valid and ack in cycle 3.
- Throughput: one write per 3 cycles, one read per 4 cycles.
- A request arriving while busy waits. It is evaluated in the next IDLE cycle.
- Reset mid-transaction:
  - the transaction is aborted and mem_cmd goes to MNONE immediately;
  - no ack is issued for it, and the requester must reissue;
  - a write aborted in ISSUE may or may not commit.
- A request that changes while busy violates the protocol. The arbiter uses its latched copy and does not check for the change.

## Test plan
- Reset: assert reset mid-cycle with clk stopped → all outputs take their reset values immediately, busy = 0.
- CPU read: cpu_cmd = 01, cpu_addr = 9'h005, memory returns 16'hABCD in cycle 2 → mem_cmd = 01 and mem_addr = 9'h005 in cycles 1–2; cpu_ack = 1 only in cycle 3; cpu_rdata = 16'hABCD held afterward; dma_rdata remains 0.
- DMA write: dma_cmd = 10, dma_addr = 9'h1FF, dma_wdata = 16'h1234 → mem_cmd = 10 with that address and data in cycle 1; dma_ack = 1 in cycle 2; owner = 1; neither rdata changes.
- Contention: both ports request reads continuously from reset → grant order CPU, DMA, CPU, DMA; acks never overlap; each ack is 4 cycles after the previous one.
- Illegal and idle: cpu_cmd = 11 with dma_cmd = 00 for 10 cycles → FSM stays in IDLE, mem_cmd = 00, no ack; then dma_cmd = 01 → DMA is granted in the next cycle.
- Reset during RWAIT of a CPU read → mem_cmd = 00 at once, no cpu_ack, cpu_rdata = 0. After release with the request still held, the read reissues and completes normally.
